// File: rtl/mux_scan_ctrl_pkg.sv
// mux_scan_pkg: shared widths and FSM state type for the 4:1 mux scan sequencer.
//   NUM_CH   - channels scanned per frame
//   SEL_W    - width of the select value driven on {s1,s0}
//   SETTLE_W - width of the settle down-counter
package mux_scan_pkg;

    localparam int unsigned NUM_CH   = 4;
    localparam int unsigned SEL_W    = 2;
    localparam int unsigned SETTLE_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// mux_scan_ctrl_if: groups the scan controller's mux-facing and consumer-facing signals.
//   start               - request one scan
//   s1, s0              - registered mux select (MSB, LSB)
//   mux_out             - output of the mux under scan
//   frame, frame_valid  - captured 4-sample frame and its valid flag
//   frame_ready         - consumer accepts the frame
//   busy                - controller is not idle
// master: the controller side; slave: the mux/consumer side.
interface mux_scan_ctrl_if;
    import mux_scan_pkg::*;

    logic              start;
    logic              s1;
    logic              s0;
    logic              mux_out;
    logic [NUM_CH-1:0] frame;
    logic              frame_valid;
    logic              frame_ready;
    logic              busy;

    modport master (
        input  start, mux_out, frame_ready,
        output s1, s0, frame, frame_valid, busy
    );

    modport slave (
        output start, mux_out, frame_ready,
        input  s1, s0, frame, frame_valid, busy
    );

endinterface

// File: rtl/mux41.sv
// mux41: plain combinational 4:1 mux; y = i[{s1,s0}].
//   i0..i3 - data inputs
//   s1, s0 - select MSB, LSB
//   y      - selected input
module mux41 (
    input  logic i0,
    input  logic i1,
    input  logic i2,
    input  logic i3,
    input  logic s1,
    input  logic s0,
    output logic y
);

    always_comb begin
        case ({s1, s0})
            2'b00:   y = i0;
            2'b01:   y = i1;
            2'b10:   y = i2;
            default: y = i3;
        endcase
    end

endmodule

// File: rtl/mux_scan_ctrl_settle_timer.sv
// settle_timer: loadable down-counter that times how long the select is held.
//   clk, rst_n - clock and synchronous active-low reset (count cleared to 0)
//   load       - load load_val (has priority over en)
//   load_val   - value to load
//   en         - decrement by one
//   zero       - count is zero
module settle_timer
    import mux_scan_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [SETTLE_W-1:0] load_val,
    input  logic                en,
    output logic                zero
);

    logic [SETTLE_W-1:0] count_q;
    logic [SETTLE_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - SETTLE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: steps a 4:1 mux select through channels 0..3, waits SETTLE_CYCLES
// after each select change, samples mux_out, and offers the packed 4-bit frame on a
// valid/ready handshake.
//   clk, rst_n - clock and synchronous active-low reset
//   bus        - mux_scan_ctrl_if.master (start, s1/s0, mux_out, frame,
//                frame_valid, frame_ready, busy)
// Parameters:
//   SETTLE_CYCLES - cycles the select is held before sampling (1..15)
//   CONTINUOUS    - restart a scan automatically after each accepted frame
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter bit          CONTINUOUS    = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    mux_scan_ctrl_if.master  bus
);

    generate
        if (SETTLE_CYCLES == 0 || SETTLE_CYCLES > ((1 << SETTLE_W) - 1)) begin : g_bad_settle
            $error("mux_scan_ctrl: SETTLE_CYCLES must be in 1..15");
        end
    endgenerate

    localparam logic [SETTLE_W-1:0] RELOAD   = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [SEL_W-1:0]    LAST_SEL = SEL_W'(NUM_CH - 1);

    state_e            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [NUM_CH-1:0] frame_q, frame_d;
    logic              valid_q, valid_d;
    logic              tmr_load;
    logic              tmr_en;
    logic              tmr_zero;

    settle_timer u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (RELOAD),
        .en       (tmr_en),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        frame_d  = frame_q;
        valid_d  = valid_q;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d  = SETTLE;
                    sel_d    = '0;
                    frame_d  = '0;
                    tmr_load = 1'b1;
                end
            end
            SETTLE: begin
                if (tmr_zero) begin
                    state_d = SAMPLE;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            SAMPLE: begin
                frame_d[sel_q] = bus.mux_out;
                if (sel_q == LAST_SEL) begin
                    state_d = DONE;
                    valid_d = 1'b1;
                end else begin
                    state_d  = SETTLE;
                    sel_d    = sel_q + SEL_W'(1);
                    tmr_load = 1'b1;
                end
            end
            DONE: begin
                if (bus.frame_ready) begin
                    valid_d = 1'b0;
                    sel_d   = '0;
                    // A restart skips IDLE so back-to-back frames have no bubble.
                    if (bus.start || CONTINUOUS) begin
                        state_d  = SETTLE;
                        frame_d  = '0;
                        tmr_load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            frame_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            frame_q <= frame_d;
            valid_q <= valid_d;
        end
    end

    assign bus.s1          = sel_q[1];
    assign bus.s0          = sel_q[0];
    assign bus.frame       = frame_q;
    assign bus.frame_valid = valid_q;
    assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: scoreboard bench for mux_scan_ctrl.
// dut_a: SETTLE_CYCLES=1, CONTINUOUS=0.  dut_b: SETTLE_CYCLES=3, CONTINUOUS=1.
// Expected frames are queued when a scan is started and compared when a handshake
// is seen; cycle-level timing is checked directly.
module tb_mux_scan_ctrl;

    logic clk;
    logic rst_n;
    logic [3:0] in_a;
    logic [3:0] in_b;

    int unsigned n_checks;
    int unsigned n_errors;

    logic [3:0] q_a[$];
    logic [3:0] q_b[$];

    mux_scan_ctrl_if ifa ();
    mux_scan_ctrl_if ifb ();

    mux41 u_mux_a (
        .i0 (in_a[0]), .i1 (in_a[1]), .i2 (in_a[2]), .i3 (in_a[3]),
        .s1 (ifa.s1), .s0 (ifa.s0), .y (ifa.mux_out)
    );

    mux41 u_mux_b (
        .i0 (in_b[0]), .i1 (in_b[1]), .i2 (in_b[2]), .i3 (in_b[3]),
        .s1 (ifb.s1), .s0 (ifb.s0), .y (ifb.mux_out)
    );

    mux_scan_ctrl #(.SETTLE_CYCLES(1), .CONTINUOUS(1'b0)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    mux_scan_ctrl #(.SETTLE_CYCLES(3), .CONTINUOUS(1'b1)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_a(input string tag);
        check_eq({tag, "_sel"},   {30'd0, ifa.s1, ifa.s0}, 32'd0);
        check_eq({tag, "_frame"}, {28'd0, ifa.frame}, 32'd0);
        check_eq({tag, "_valid"}, {31'd0, ifa.frame_valid}, 32'd0);
        check_eq({tag, "_busy"},  {31'd0, ifa.busy}, 32'd0);
    endtask

    task automatic wait_valid_a(input int unsigned budget);
        for (int unsigned i = 0; i < budget && ifa.frame_valid !== 1'b1; i++) tick();
        check_eq("a_valid_wait", {31'd0, ifa.frame_valid}, 32'd1);
    endtask

    task automatic wait_valid_b(input int unsigned budget);
        for (int unsigned i = 0; i < budget && ifb.frame_valid !== 1'b1; i++) tick();
        check_eq("b_valid_wait", {31'd0, ifb.frame_valid}, 32'd1);
    endtask

    // Handshakes are observed mid-cycle, where frame, valid and ready are all stable.
    always @(negedge clk) begin
        logic [3:0] exp;
        if (ifa.frame_valid === 1'b1 && ifa.frame_ready === 1'b1) begin
            exp = (q_a.size() > 0) ? q_a.pop_front() : 4'hx;
            check_eq("sb_a_frame", {28'd0, ifa.frame}, {28'd0, exp});
        end
        if (ifb.frame_valid === 1'b1 && ifb.frame_ready === 1'b1) begin
            exp = (q_b.size() > 0) ? q_b.pop_front() : 4'hx;
            check_eq("sb_b_frame", {28'd0, ifb.frame}, {28'd0, exp});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        in_a = 4'b0000;
        in_b = 4'b0000;
        ifa.start = 1'b0;
        ifa.frame_ready = 1'b0;
        ifb.start = 1'b0;
        ifb.frame_ready = 1'b0;

        // 1. reset and idle hold
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            check_idle_a("t1_a");
            check_eq("t1_b_busy",  {31'd0, ifb.busy}, 32'd0);
            check_eq("t1_b_valid", {31'd0, ifb.frame_valid}, 32'd0);
            tick();
        end

        // 2. single scan, settle 1: select sequence and latency E+8
        in_a = 4'b0101;
        ifa.frame_ready = 1'b1;
        ifa.start = 1'b1;
        q_a.push_back(4'b0101);
        tick();
        ifa.start = 1'b0;
        for (int k = 0; k <= 8; k++) begin
            check_eq("t2_sel",   {30'd0, ifa.s1, ifa.s0}, (k < 8) ? k / 2 : 3);
            check_eq("t2_valid", {31'd0, ifa.frame_valid}, (k == 8) ? 1 : 0);
            check_eq("t2_busy",  {31'd0, ifa.busy}, 32'd1);
            if (k != 8) tick();
        end
        check_eq("t2_frame", {28'd0, ifa.frame}, 32'h5);
        tick();
        check_eq("t2_valid_drop", {31'd0, ifa.frame_valid}, 32'd0);
        check_eq("t2_idle_busy",  {31'd0, ifa.busy}, 32'd0);
        check_eq("t2_idle_sel",   {30'd0, ifa.s1, ifa.s0}, 32'd0);
        check_eq("t2_sb_drained", q_a.size(), 32'd0);

        // 3. backpressure; start pulses in DONE without handshake are ignored
        ifa.frame_ready = 1'b0;
        ifa.start = 1'b1;
        q_a.push_back(4'b0101);
        tick();
        ifa.start = 1'b0;
        wait_valid_a(40);
        for (int c = 0; c < 10; c++) begin
            check_eq("t3_valid", {31'd0, ifa.frame_valid}, 32'd1);
            check_eq("t3_frame", {28'd0, ifa.frame}, 32'h5);
            check_eq("t3_sel",   {30'd0, ifa.s1, ifa.s0}, 32'd3);
            ifa.start = (c % 3 == 0);
            tick();
        end
        ifa.start = 1'b0;
        check_eq("t3_valid_end", {31'd0, ifa.frame_valid}, 32'd1);
        ifa.frame_ready = 1'b1;
        tick();
        ifa.frame_ready = 1'b0;
        check_eq("t3_hs_valid", {31'd0, ifa.frame_valid}, 32'd0);
        check_eq("t3_hs_busy",  {31'd0, ifa.busy}, 32'd0);
        check_eq("t3_hs_sel",   {30'd0, ifa.s1, ifa.s0}, 32'd0);
        tick();
        tick();
        check_eq("t3_no_queue_busy", {31'd0, ifa.busy}, 32'd0);
        check_eq("t3_sb_drained", q_a.size(), 32'd0);

        // 4. continuous, settle 3: second frame 16 edges after first handshake
        in_b = 4'b0101;
        ifb.start = 1'b1;
        q_b.push_back(4'b0101);
        tick();
        ifb.start = 1'b0;
        wait_valid_b(80);
        in_b = 4'b0110;
        q_b.push_back(4'b0110);
        ifb.frame_ready = 1'b1;
        tick();
        ifb.frame_ready = 1'b0;
        check_eq("t4_hs_valid", {31'd0, ifb.frame_valid}, 32'd0);
        check_eq("t4_hs_busy",  {31'd0, ifb.busy}, 32'd1);
        check_eq("t4_hs_sel",   {30'd0, ifb.s1, ifb.s0}, 32'd0);
        for (int k = 1; k < 16; k++) tick();
        check_eq("t4_valid_e15", {31'd0, ifb.frame_valid}, 32'd0);
        tick();
        check_eq("t4_valid_e16", {31'd0, ifb.frame_valid}, 32'd1);
        check_eq("t4_frame2",    {28'd0, ifb.frame}, 32'h6);
        ifb.frame_ready = 1'b1;
        tick();
        ifb.frame_ready = 1'b0;
        check_eq("t4_sb_drained", q_b.size(), 32'd0);

        // 5. reset during SAMPLE of channel 2, then a clean scan
        in_a = 4'b0011;
        ifa.frame_ready = 1'b1;
        ifa.start = 1'b1;
        q_a.push_back(4'b0011);
        tick();
        ifa.start = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        check_eq("t5_pre_sel",  {30'd0, ifa.s1, ifa.s0}, 32'd2);
        check_eq("t5_pre_busy", {31'd0, ifa.busy}, 32'd1);
        rst_n = 1'b0;
        q_a.delete();
        tick();
        check_idle_a("t5_rst");
        rst_n = 1'b1;
        in_a = 4'b1101;
        ifa.start = 1'b1;
        q_a.push_back(4'b1101);
        tick();
        ifa.start = 1'b0;
        wait_valid_a(40);
        check_eq("t5_frame", {28'd0, ifa.frame}, 32'hd);
        tick();
        check_eq("t5_sb_drained", q_a.size(), 32'd0);
        check_eq("t5_end_busy", {31'd0, ifa.busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
